sub_m: RTL and testbench



---
 rtl/coproc_pkg.sv | 27 ++
 rtl/sub_lane.sv | 30 +++
 rtl/sub_m.sv | 62 ++++++
 tb/tb_sub_m.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// ---------------------------------------------------------------------------
// coproc_pkg
//   Shared constants and types for the matrix coprocessor datapath.
//   A matrix row is packed into one W-bit word of LANES signed EW-bit
//   elements; lane i occupies bits [EW*i +: EW], lane LANES-1 is the MSB lane.
//
//   LANES   elements per packed row
//   EW      element width (two's complement)
//   W       packed row width
//   elem_t  one signed element
//   row_t   one packed row
//   lane_slice(row, idx)  extract element idx from a packed row
// ---------------------------------------------------------------------------
package coproc_pkg;

    localparam int unsigned LANES = 5;
    localparam int unsigned EW    = 8;
    localparam int unsigned W     = LANES * EW;

    typedef logic signed [EW-1:0] elem_t;
    typedef logic        [W-1:0]  row_t;

    function automatic elem_t lane_slice(input row_t row, input int unsigned idx);
        return elem_t'(row[EW*idx +: EW]);
    endfunction

endpackage

// File: rtl/sub_lane.sv
// ---------------------------------------------------------------------------
// sub_lane
//   Combinational signed subtract of one packed element: d = a - b, wrapped
//   to EW bits (no saturation), with a signed-overflow flag.
//
//   a_i   signed minuend element
//   b_i   signed subtrahend element
//   d_o   a_i - b_i truncated to EW bits
//   ov_o  1 when the true difference does not fit in EW signed bits
// ---------------------------------------------------------------------------
module sub_lane
    import coproc_pkg::*;
(
    input  elem_t a_i,
    input  elem_t b_i,
    output elem_t d_o,
    output logic  ov_o
);

    elem_t diff;

    always_comb begin
        diff = a_i - b_i;
        d_o  = diff;
        // Overflow only possible when operand signs differ; it shows up as
        // the result sign disagreeing with the minuend sign.
        ov_o = (a_i[EW-1] != b_i[EW-1]) && (diff[EW-1] != a_i[EW-1]);
    end

endmodule

// File: rtl/sub_m.sv
// ---------------------------------------------------------------------------
// sub_m
//   Lane-wise signed subtractor: m_out = m1 - m2 over LANES packed EW-bit
//   elements. Lanes are independent (no borrow crosses a lane boundary).
//   Result and overflow are registered, one cycle latency, no enable.
//
//   clk    rising-edge clock
//   rst    asynchronous active-high reset; clears m_out and ovf at once
//   m1     packed signed minuend row
//   m2     packed signed subtrahend row
//   m_out  packed signed difference row (registered)
//   ovf    OR of all per-lane overflow flags (registered)
// ---------------------------------------------------------------------------
module sub_m
    import coproc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  row_t m1,
    input  row_t m2,
    output row_t m_out,
    output logic ovf
);

    row_t             diff_row;
    logic [LANES-1:0] lane_ov;

    row_t m_out_q, m_out_d;
    logic ovf_q,   ovf_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        elem_t lane_d;

        sub_lane u_sub_lane (
            .a_i  (lane_slice(m1, g)),
            .b_i  (lane_slice(m2, g)),
            .d_o  (lane_d),
            .ov_o (lane_ov[g])
        );

        assign diff_row[EW*g +: EW] = lane_d;
    end

    always_comb begin
        m_out_d = diff_row;
        ovf_d   = |lane_ov;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            m_out_q <= m_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_out = m_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_m.sv
// ---------------------------------------------------------------------------
// tb_sub_m
//   Directed self-checking bench for sub_m. Rows are written MSB lane first.
// ---------------------------------------------------------------------------
module tb_sub_m;
    import coproc_pkg::*;

    logic clk;
    logic rst;
    row_t m1;
    row_t m2;
    row_t m_out;
    logic ovf;

    int checks;
    int failures;

    sub_m dut (
        .clk   (clk),
        .rst   (rst),
        .m1    (m1),
        .m2    (m2),
        .m_out (m_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held from t=0: outputs clear before any edge and stay clear.
    task automatic test_reset();
        #1;
        checks++;
        if (m_out !== 40'h0) begin
            failures++;
            $display("FAIL reset_m_out_pre_clk got=%h want=%h", m_out, 40'h0);
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf_pre_clk got=%b want=0", ovf);
        end
        m1 = 40'h32_80_7F_9C_64;
        m2 = 40'h9C_FF_01_1E_1E;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_out !== 40'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_held got=%h/%b want=%h/0", m_out, ovf, 40'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Plain differences, mixed signs, no overflow.
    task automatic test_basic();
        row_t a[2]   = '{40'h32_28_1E_14_0A, 40'h32_D8_1E_EC_0A};
        row_t b[2]   = '{40'h2D_23_19_0F_05, 40'hD3_23_E7_0F_FB};
        row_t exp[2] = '{40'h05_05_05_05_05, 40'h5F_B5_37_DD_0F};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m1 = a[i];
            m2 = b[i];
            @(posedge clk);
            #1;
            checks++;
            if (m_out !== exp[i] || ovf !== 1'b0) begin
                failures++;
                $display("FAIL basic_%0d got=%h/%b want=%h/0", i, m_out, ovf, exp[i]);
            end
        end
    endtask

    // Two lanes wrap; flag raised.
    task automatic test_wrap();
        @(negedge clk);
        m1 = 40'h32_80_7F_9C_64;
        m2 = 40'h9C_FF_01_1E_1E;
        @(posedge clk);
        #1;
        checks++;
        if (m_out !== 40'h96_81_7E_7E_46) begin
            failures++;
            $display("FAIL wrap_m_out got=%h want=%h", m_out, 40'h96_81_7E_7E_46);
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL wrap_ovf got=%b want=1", ovf);
        end
    endtask

    // Lane 0 at -128: 0-(-128) overflows, -128-0 does not.
    task automatic test_single_lane();
        row_t a[2]   = '{40'h00_00_00_00_00, 40'h00_00_00_00_80};
        row_t b[2]   = '{40'h00_00_00_00_80, 40'h00_00_00_00_00};
        logic eov[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m1 = a[i];
            m2 = b[i];
            @(posedge clk);
            #1;
            checks++;
            if (m_out !== 40'h00_00_00_00_80 || ovf !== eov[i]) begin
                failures++;
                $display("FAIL single_lane_%0d got=%h/%b want=%h/%b",
                         i, m_out, ovf, 40'h00_00_00_00_80, eov[i]);
            end
        end
    endtask

    // Boundary values and lane isolation, new vector every cycle.
    task automatic test_back_to_back();
        row_t a[4]   = '{40'h80_32_7F_80_0A, 40'h80_32_7F_80_0A,
                         40'h00_00_00_00_00, 40'h00_00_00_01_00};
        row_t b[4]   = '{40'h00_32_FF_80_0A, 40'h00_32_00_80_0A,
                         40'h00_00_00_00_01, 40'h00_00_00_00_01};
        row_t exp[4] = '{40'h80_00_80_00_00, 40'h80_00_7F_00_00,
                         40'h00_00_00_00_FF, 40'h00_00_00_01_FF};
        logic eov[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            m1 = a[i];
            m2 = b[i];
            @(posedge clk);
            #1;
            checks++;
            if (m_out !== exp[i] || ovf !== eov[i]) begin
                failures++;
                $display("FAIL b2b_%0d got=%h/%b want=%h/%b", i, m_out, ovf, exp[i], eov[i]);
            end
            #4;
        end
    endtask

    // Reset pulsed between edges clears at once; next edge restores result.
    task automatic test_mid_reset();
        @(negedge clk);
        m1 = 40'h32_80_7F_9C_64;
        m2 = 40'h9C_FF_01_1E_1E;
        @(posedge clk);
        #1;
        checks++;
        if (m_out !== 40'h96_81_7E_7E_46 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL midrst_before got=%h/%b want=%h/1", m_out, ovf, 40'h96_81_7E_7E_46);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (m_out !== 40'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async_clear got=%h/%b want=%h/0", m_out, ovf, 40'h0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_out !== 40'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after_release got=%h/%b want=%h/0", m_out, ovf, 40'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_out !== 40'h96_81_7E_7E_46 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restore got=%h/%b want=%h/1", m_out, ovf, 40'h96_81_7E_7E_46);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        m1       = '0;
        m2       = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_single_lane();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
